// File: rtl/mem_readback_pkg.sv
// Shared types and sizes for the memory readback / programmer slice.
package mem_readback_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        SHOW_HI = 3'd3,
        SHOW_LO = 3'd4
    } state_t;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int MAX_LATENCY = 4;
    // Latency counter runs READ_LATENCY-1 down to 0.
    localparam int LAT_W       = $clog2(MAX_LATENCY);

    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/mem_readback_edge_rise.sv
// Registered rising-edge detector; the reset level of the delayed copy is configurable.
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pos
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= RST_VAL;
        else     d_q <= d;
    end

    assign pos = d & ~d_q;

endmodule

// File: rtl/mem_readback.sv
// Switch-driven memory readback: reads one word, shows high then low byte,
// then auto-advances to the next address.
module mem_readback
    import mem_readback_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] switch,
    input  logic              enter,
    input  logic              newAddr,
    output logic [ADDR_W-1:0] addrRd,
    output logic              rdEn,
    input  logic [DATA_W-1:0] dataRd,
    output logic [7:0]        dispData,
    output logic              dispHigh,
    output logic              busy
);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr_n;
    logic               rd_en_n;
    logic [DATA_W-1:0]  word, word_n;
    logic [7:0]         disp_n;
    logic               disp_hi_n;
    logic [LAT_W-1:0]   cnt, cnt_n;
    logic               enter_pos;

    // Delayed copy resets high so a button held through reset does not fire.
    edge_rise #(.RST_VAL(1'b1)) u_enter_edge (
        .clk (clk),
        .rst (rst),
        .d   (enter),
        .pos (enter_pos)
    );

    assign busy = (state == REQ) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addrRd   <= '0;
            rdEn     <= 1'b0;
            word     <= '0;
            dispData <= '0;
            dispHigh <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            addrRd   <= addr_n;
            rdEn     <= rd_en_n;
            word     <= word_n;
            dispData <= disp_n;
            dispHigh <= disp_hi_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addrRd;
        word_n    = word;
        disp_n    = dispData;
        disp_hi_n = dispHigh;
        cnt_n     = cnt;
        unique case (state)
            IDLE: begin
                if (enter_pos) begin
                    addr_n  = switch;
                    state_n = REQ;
                end
            end
            REQ: begin
                cnt_n   = LAT_W'(READ_LATENCY - 1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    word_n    = dataRd;
                    disp_n    = byte_sel(dataRd, 1'b1);
                    disp_hi_n = 1'b1;
                    state_n   = SHOW_HI;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SHOW_HI: begin
                if (enter_pos) begin
                    if (newAddr) begin
                        addr_n  = switch;
                        state_n = REQ;
                    end else begin
                        disp_n    = byte_sel(word, 1'b0);
                        disp_hi_n = 1'b0;
                        state_n   = SHOW_LO;
                    end
                end
            end
            SHOW_LO: begin
                if (enter_pos) begin
                    addr_n  = newAddr ? switch : addrRd + 1'b1;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
        // Strobe is registered: it is high exactly in the cycle spent in REQ.
        rd_en_n = (state_n == REQ);
    end

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: latency-1 and latency-3 instances against a memory model.
module tb_mem_readback;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  switch = '0, switch3 = '0;
    logic        enter = 1'b0, enter3 = 1'b0, newAddr = 1'b0, newAddr3 = 1'b0;
    logic [7:0]  addrRd, addrRd3, dispData, dispData3;
    logic        rdEn, rdEn3, dispHigh, dispHigh3, busy, busy3;
    logic [15:0] dataRd, dataRd3;

    logic [15:0] mem [256];
    int errs = 0, checks = 0;
    int n_rd1 = 0, n_rd3 = 0;

    mem_readback #(.READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .switch(switch), .enter(enter), .newAddr(newAddr),
        .addrRd(addrRd), .rdEn(rdEn), .dataRd(dataRd),
        .dispData(dispData), .dispHigh(dispHigh), .busy(busy));

    mem_readback #(.READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .switch(switch3), .enter(enter3), .newAddr(newAddr3),
        .addrRd(addrRd3), .rdEn(rdEn3), .dataRd(dataRd3),
        .dispData(dispData3), .dispHigh(dispHigh3), .busy(busy3));

    // Memory returns data only in the READ_LATENCY-th cycle after the strobe.
    logic       v1 = 1'b0;
    logic [7:0] a1 = '0;
    logic [2:0] v3 = '0;
    logic [7:0] a3 [3];
    always @(posedge clk) begin
        v1 <= rdEn;
        a1 <= addrRd;
        v3 <= {v3[1:0], rdEn3};
        a3[0] <= addrRd3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
        if (rdEn)  n_rd1 <= n_rd1 + 1;
        if (rdEn3) n_rd3 <= n_rd3 + 1;
    end
    assign dataRd  = v1    ? mem[a1]    : 16'hxxxx;
    assign dataRd3 = v3[2] ? mem[a3[2]] : 16'hxxxx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one enter press in the current cycle (N); returns positioned in N+1.
    task automatic press(input logic [7:0] sw, input logic na);
        switch  = sw;
        newAddr = na;
        enter   = 1'b1;
        tick();
        enter   = 1'b0;
        newAddr = 1'b0;
    endtask

    task automatic test_reset();
        enter = 1'b1;
        repeat (3) tick();
        checks++; if (addrRd !== 8'h00)  begin errs++; $display("FAIL reset_addr got=%h want=00", addrRd); end
        checks++; if (rdEn !== 1'b0)     begin errs++; $display("FAIL reset_rden got=%b want=0", rdEn); end
        checks++; if (dispData !== 8'h00) begin errs++; $display("FAIL reset_disp got=%h want=00", dispData); end
        checks++; if (dispHigh !== 1'b0) begin errs++; $display("FAIL reset_disphigh got=%b want=0", dispHigh); end
        checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (dispData3 !== 8'h00) begin errs++; $display("FAIL reset_disp3 got=%h want=00", dispData3); end
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || n_rd1 !== 0) begin errs++; $display("FAIL reset_held_enter busy=%b reads=%0d want 0/0", busy, n_rd1); end
        enter = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int base;
        base = n_rd1;
        press(8'h05, 1'b0);
        checks++; if (rdEn !== 1'b1)    begin errs++; $display("FAIL basic_rden_n1 got=%b want=1", rdEn); end
        checks++; if (addrRd !== 8'h05) begin errs++; $display("FAIL basic_addr got=%h want=05", addrRd); end
        checks++; if (busy !== 1'b1)    begin errs++; $display("FAIL basic_busy got=%b want=1", busy); end
        tick();
        checks++; if (rdEn !== 1'b0)     begin errs++; $display("FAIL basic_rden_n2 got=%b want=0", rdEn); end
        checks++; if (dispData !== 8'h00) begin errs++; $display("FAIL basic_disp_hold got=%h want=00", dispData); end
        tick();
        checks++; if (dispData !== 8'hA5 || dispHigh !== 1'b1) begin errs++; $display("FAIL basic_disp got=%h/%b want=a5/1", dispData, dispHigh); end
        checks++; if (busy !== 1'b0)    begin errs++; $display("FAIL basic_busy_end got=%b want=0", busy); end
        checks++; if (n_rd1 - base !== 1) begin errs++; $display("FAIL basic_pulses got=%0d want=1", n_rd1 - base); end
    endtask

    task automatic test_step();
        int base;
        tick();
        press(8'h00, 1'b0);
        checks++; if (dispData !== 8'h5A || dispHigh !== 1'b0) begin errs++; $display("FAIL step_lo got=%h/%b want=5a/0", dispData, dispHigh); end
        checks++; if (rdEn !== 1'b0) begin errs++; $display("FAIL step_no_read got=%b want=0", rdEn); end
        tick();
        base = n_rd1;
        press(8'h00, 1'b0);
        checks++; if (addrRd !== 8'h06 || rdEn !== 1'b1) begin errs++; $display("FAIL step_advance got=%h/%b want=06/1", addrRd, rdEn); end
        repeat (2) tick();
        checks++; if (dispData !== 8'h12 || dispHigh !== 1'b1) begin errs++; $display("FAIL step_next_hi got=%h/%b want=12/1", dispData, dispHigh); end
        checks++; if (n_rd1 - base !== 1) begin errs++; $display("FAIL step_pulses got=%0d want=1", n_rd1 - base); end
    endtask

    task automatic test_wrap();
        tick();
        press(8'hFF, 1'b1);
        repeat (2) tick();
        checks++; if (addrRd !== 8'hFF || dispData !== 8'hBE) begin errs++; $display("FAIL wrap_ff got=%h/%h want=ff/be", addrRd, dispData); end
        tick();
        press(8'h00, 1'b0);
        checks++; if (dispData !== 8'hEF) begin errs++; $display("FAIL wrap_ff_lo got=%h want=ef", dispData); end
        tick();
        press(8'h00, 1'b0);
        checks++; if (addrRd !== 8'h00) begin errs++; $display("FAIL wrap_addr got=%h want=00", addrRd); end
        repeat (2) tick();
        checks++; if (dispData !== 8'hC0 || dispHigh !== 1'b1) begin errs++; $display("FAIL wrap_disp got=%h/%b want=c0/1", dispData, dispHigh); end
    endtask

    task automatic test_reload_drop();
        int base;
        tick();
        base = n_rd1;
        press(8'h40, 1'b1);
        checks++; if (addrRd !== 8'h40) begin errs++; $display("FAIL reload_addr got=%h want=40", addrRd); end
        tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL reload_busy got=%b want=1", busy); end
        switch = 8'h99; newAddr = 1'b1; enter = 1'b1;
        tick();
        enter = 1'b0; newAddr = 1'b0;
        checks++; if (dispData !== 8'h7E || dispHigh !== 1'b1) begin errs++; $display("FAIL reload_disp got=%h/%b want=7e/1", dispData, dispHigh); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || addrRd !== 8'h40) begin errs++; $display("FAIL drop_state busy=%b addr=%h want 0/40", busy, addrRd); end
        checks++; if (n_rd1 - base !== 1) begin errs++; $display("FAIL drop_pulses got=%0d want=1", n_rd1 - base); end
        press(8'h00, 1'b0);
        checks++; if (dispData !== 8'h81 || dispHigh !== 1'b0) begin errs++; $display("FAIL drop_was_show_hi got=%h/%b want=81/0", dispData, dispHigh); end
    endtask

    // Model: current address and which byte is shown, advanced by the press rules.
    task automatic test_random();
        logic [7:0] addr, sw;
        logic       lo, na, rd, drop;
        logic [7:0] exp;
        int         base;
        addr = 8'h40;
        lo   = 1'b1;
        for (int i = 0; i < 24; i++) begin
            sw = 8'($urandom);
            na = ($urandom % 3) == 0;
            if (na)       begin addr = sw; rd = 1'b1; lo = 1'b0; end
            else if (!lo) begin rd = 1'b0; lo = 1'b1; end
            else          begin addr = addr + 8'd1; rd = 1'b1; lo = 1'b0; end
            drop = rd && (($urandom % 2) == 1);
            base = n_rd1;
            tick();
            press(sw, na);
            tick();
            if (drop) enter = 1'b1;
            tick();
            enter = 1'b0;
            repeat (2) tick();
            exp = lo ? mem[addr][7:0] : mem[addr][15:8];
            checks++; if (addrRd !== addr) begin errs++; $display("FAIL rand_addr[%0d] got=%h want=%h", i, addrRd, addr); end
            checks++; if (dispData !== exp) begin errs++; $display("FAIL rand_disp[%0d] got=%h want=%h", i, dispData, exp); end
            checks++; if (dispHigh !== !lo) begin errs++; $display("FAIL rand_high[%0d] got=%b want=%b", i, dispHigh, !lo); end
            checks++; if (n_rd1 - base !== int'(rd)) begin errs++; $display("FAIL rand_pulses[%0d] got=%0d want=%0d", i, n_rd1 - base, rd); end
        end
    endtask

    task automatic test_latency();
        logic [7:0]  a;
        logic [15:0] w;
        int          base;
        a = 8'($urandom);
        w = 16'($urandom) | 16'h8000;
        mem[a] = w;
        base = n_rd3;
        switch3 = a; enter3 = 1'b1;
        tick();
        enter3 = 1'b0;
        checks++; if (rdEn3 !== 1'b1 || addrRd3 !== a) begin errs++; $display("FAIL lat3_req got=%b/%h want=1/%h", rdEn3, addrRd3, a); end
        repeat (3) tick();
        checks++; if (dispData3 !== 8'h00 || busy3 !== 1'b1) begin errs++; $display("FAIL lat3_n4 disp=%h busy=%b want 00/1", dispData3, busy3); end
        tick();
        checks++; if (dispData3 !== w[15:8] || dispHigh3 !== 1'b1) begin errs++; $display("FAIL lat3_n5 got=%h/%b want=%h/1", dispData3, dispHigh3, w[15:8]); end
        checks++; if (busy3 !== 1'b0) begin errs++; $display("FAIL lat3_busy got=%b want=0", busy3); end
        tick();
        enter3 = 1'b1;
        tick();
        enter3 = 1'b0;
        checks++; if (dispData3 !== w[7:0] || dispHigh3 !== 1'b0) begin errs++; $display("FAIL lat3_lo got=%h/%b want=%h/0", dispData3, dispHigh3, w[7:0]); end
        checks++; if (n_rd3 - base !== 1) begin errs++; $display("FAIL lat3_pulses got=%0d want=1", n_rd3 - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        tick();
        switch = 8'h33; newAddr = 1'b1; enter = 1'b1;
        tick();
        checks++; if (rdEn !== 1'b1) begin errs++; $display("FAIL rmid_req got=%b want=1", rdEn); end
        tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_wait got=%b want=1", busy); end
        rst = 1'b1;
        tick();
        checks++; if (addrRd !== 8'h00 || rdEn !== 1'b0) begin errs++; $display("FAIL rmid_addr_rden got=%h/%b want=00/0", addrRd, rdEn); end
        checks++; if (dispData !== 8'h00 || dispHigh !== 1'b0) begin errs++; $display("FAIL rmid_disp got=%h/%b want=00/0", dispData, dispHigh); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b want=0", busy); end
        rst = 1'b0; newAddr = 1'b0;
        base = n_rd1;
        repeat (4) tick();
        checks++; if (busy !== 1'b0 || n_rd1 !== base) begin errs++; $display("FAIL rmid_held busy=%b reads=%0d want 0/0", busy, n_rd1 - base); end
        checks++; if (dispData !== 8'h00) begin errs++; $display("FAIL rmid_no_capture got=%h want=00", dispData); end
        enter = 1'b0;
        tick();
        press(8'h33, 1'b0);
        repeat (2) tick();
        checks++; if (addrRd !== 8'h33 || dispData !== 8'h5A) begin errs++; $display("FAIL rmid_repress got=%h/%h want=33/5a", addrRd, dispData); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h05] = 16'hA55A;
        mem[8'h06] = 16'h1234;
        mem[8'hFF] = 16'hBEEF;
        mem[8'h00] = 16'hC0DE;
        mem[8'h40] = 16'h7E81;
        test_reset();
        test_basic();
        test_step();
        test_wrap();
        test_reload_drop();
        test_random();
        test_latency();
        mem[8'h33] = 16'h5AC3;
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
